// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - snake move tick generator with a two-entry turn buffer
// Turns are accepted against the newest pending direction and applied one per move tick.
module move_scheduler #(
    parameter int TICK_BASE = 25_000_000,
    parameter int CNT_W     = 25
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       speed_level,
    input  logic             key_valid,
    input  logic [1:0]       key_dir,
    output logic [1:0]       direction,
    output logic             step_tick,
    output logic             key_drop,
    output logic [1:0]       queue_cnt,
    output logic             running
);
    // Opposite directions differ only in bit 0.
    localparam logic [1:0] TOP_DIR   = 2'd0;
    localparam logic [1:0] DOWN_DIR  = 2'd1;
    localparam logic [1:0] LEFT_DIR  = 2'd2;
    localparam logic [1:0] RIGHT_DIR = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         q0_q, q0_d, q1_q, q1_d;
    logic [1:0]         qcnt_q, qcnt_d;
    logic               tick_q, tick_d;
    logic               drop_q, drop_d;
    logic               run_q, run_d;

    logic [CNT_W-1:0]   period_m1;
    logic [1:0]         ref_dir;
    logic               reject;
    logic               push;
    logic               tick_now;

    assign period_m1 = (CNT_W'(TICK_BASE) >> speed_level) - CNT_W'(1);
    assign ref_dir   = (qcnt_q == 2'd2) ? q1_q : ((qcnt_q == 2'd1) ? q0_q : dir_q);
    assign reject    = (key_dir == ref_dir) || (key_dir == (ref_dir ^ 2'b01)) || (qcnt_q == 2'd2);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        q0_d     = q0_q;
        q1_d     = q1_q;
        qcnt_d   = qcnt_q;
        drop_d   = 1'b0;
        push     = 1'b0;
        tick_now = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                qcnt_d = 2'd0;
                if (start) begin
                    state_d = S_RUN;
                    dir_d   = TOP_DIR;
                end
            end
            S_RUN, S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    qcnt_d  = 2'd0;
                end else if (start) begin
                    state_d = S_RUN;
                    dir_d   = TOP_DIR;
                    cnt_d   = '0;
                    qcnt_d  = 2'd0;
                end else if (state_q == S_PAUSE) begin
                    drop_d = key_valid;
                    if (!pause) state_d = S_RUN;
                end else begin
                    if (key_valid) begin
                        drop_d = reject;
                        push   = !reject;
                    end
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else if (cnt_q >= period_m1) begin
                        tick_now = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pop first, then push into the slot left after the pop.
        if (tick_now && qcnt_q != 2'd0) begin
            dir_d  = q0_q;
            q0_d   = q1_q;
            qcnt_d = qcnt_q - 2'd1;
        end
        if (push) begin
            if (qcnt_d == 2'd0) q0_d = key_dir;
            else                q1_d = key_dir;
            qcnt_d = qcnt_d + 2'd1;
        end

        tick_d = tick_now;
        run_d  = (state_d == S_RUN);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= TOP_DIR;
            q0_q    <= TOP_DIR;
            q1_q    <= TOP_DIR;
            qcnt_q  <= 2'd0;
            tick_q  <= 1'b0;
            drop_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            qcnt_q  <= qcnt_d;
            tick_q  <= tick_d;
            drop_q  <= drop_d;
            run_q   <= run_d;
        end
    end

    assign direction = dir_q;
    assign step_tick = tick_q;
    assign key_drop  = drop_q;
    assign queue_cnt = qcnt_q;
    assign running   = run_q;

    logic unused_dirs;
    assign unused_dirs = ^{DOWN_DIR, LEFT_DIR, RIGHT_DIR};
endmodule
